// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle.
//   master : fetch unit side (drives imem request/address and decode outputs)
//   slave  : environment side (instruction memory, redirect source, decode)
// Signals:
//   imem_req/imem_addr   read request and word-aligned byte address
//   imem_rdata           read data, returned one cycle after imem_req
//   redirect/redirect_pc taken branch/jump and its target
//   id_valid/id_ready    decode handshake; id_instr/id_pc carry the word
interface instruction_fetch_if #(
  parameter int XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word reads to a fixed 1-cycle-latency
// instruction memory and queues returned words in a 2-entry {instr, pc}
// FIFO whose head drives the decode handshake.
// Ports:
//   clk, rst_n  clock; synchronous active-low reset
//   bus         instruction_fetch_if.master (imem, redirect, decode)
//   perf_fetched, perf_flushed  (only with FETCH_PERF_CNT_EN defined)
//               handshake count / flushing-redirect count, wrap at 2^32
// Optional feature macro: FETCH_PERF_CNT_EN
module instruction_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed
`endif
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q;   // address tag of the request in flight
  logic             inflight_q;
  logic [1:0]       cnt_q, cnt_d;
  entry_t [1:0]     ent_q, ent_d; // ent_q[0] is the head
  entry_t           new_ent;
  logic             hs, req, push;
  logic [2:0]       level;

  always_comb begin
    hs      = (cnt_q != 2'd0) & bus.id_ready;
    // Slots committed after this cycle: hs implies cnt_q >= 1, no underflow.
    level   = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, hs};
    req     = rst_n & ~bus.redirect & (level <= 3'd1);
    // Data returning in a redirect cycle belongs to the old path: it is
    // discarded here rather than written. With fixed 1-cycle latency and no
    // request issued during a redirect, nothing older can still be in flight.
    push    = inflight_q & ~bus.redirect;
    new_ent = '{instr: bus.imem_rdata, pc: req_pc_q};

    ent_d = ent_q;
    cnt_d = cnt_q;
    if (bus.redirect) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, hs})
        2'b01: begin
          ent_d[0] = ent_q[1];
          cnt_d    = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) ent_d[0] = new_ent;
          else               ent_d[1] = new_ent;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            ent_d[0] = ent_q[1];
            ent_d[1] = new_ent;
          end else begin
            ent_d[0] = new_ent;
          end
        end
        default: ;
      endcase
    end

    if (bus.redirect)  pc_d = bus.redirect_pc & ~XLEN'(3);
    else if (req)      pc_d = pc_q + XLEN'(4); // wraps modulo 2^XLEN
    else               pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      ent_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= req;
      if (req) req_pc_q <= pc_q;
      cnt_q      <= cnt_d;
      ent_q      <= ent_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = (cnt_q != 2'd0);
  assign bus.id_instr  = ent_q[0].instr;
  assign bus.id_pc     = ent_q[0].pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + {31'd0, hs};
      // Only redirects that actually throw away queued or returning work.
      flushed_q <= flushed_q +
                   {31'd0, bus.redirect & ((cnt_q != 2'd0) | inflight_q)};
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam int          XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  instruction_fetch #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    if (a == 64'h0) return 32'h00730233;
    if (a == 64'h4) return 32'h40b504b3;
    lo = a[31:0];
    return (lo * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory: data one cycle after the request; junk when not requested.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hBAD0BAD0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard of expected decode PCs; reloaded on every driven redirect/reset.
  logic [63:0] exp_q[$];
  int          hs_cnt = 0;

  function automatic void sb_reload(input logic [63:0] t);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(t + 64'(4 * i));
  endfunction

  initial begin : monitor
    logic        hold_prev;
    logic [63:0] pc_prev, e;
    logic [31:0] ins_prev;
    hold_prev = 1'b0;
    pc_prev   = '0;
    ins_prev  = '0;
    forever begin
      @(negedge clk);
      if (hold_prev) begin
        chk("hold_valid", bus.id_valid, 1);
        chk("hold_pc", bus.id_pc, pc_prev);
        chk("hold_instr", bus.id_instr, ins_prev);
      end
      if (bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.id_pc, e);
        chk("sb_instr", bus.id_instr, mem_word(e));
        exp_q.push_back(exp_q[$] + 64'd4);
        hs_cnt++;
      end
      hold_prev = rst_n && !bus.redirect && (bus.id_valid === 1'b1) && !bus.id_ready;
      pc_prev   = bus.id_pc;
      ins_prev  = bus.id_instr;
      if (!rst_n) begin
        sb_reload(RST_PC);
        hs_cnt = 0;
      end else if (bus.redirect) begin
        sb_reload(bus.redirect_pc & ~64'h3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] rpc;     // redirect_pc driven
    int          stall;   // id_ready=0 cycles before the redirect
    bit          rdy;     // id_ready during the redirect cycle
    logic [63:0] exp_pc;  // expected imem_addr / first new-path id_pc
  } vec_t;

  vec_t tbl[6];
  int   exp_flushed = 0;
  int   nreq;

  initial begin
    tbl[0] = '{64'h100,                 0, 1'b0, 64'h100};
    tbl[1] = '{64'h103,                 3, 1'b0, 64'h100};
    tbl[2] = '{64'h200,                 0, 1'b1, 64'h200};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[4] = '{64'h7,                   2, 1'b0, 64'h4};
    tbl[5] = '{64'h1000,                0, 1'b1, 64'h1000};

    // Reset, with a redirect held to show reset wins.
    rst_n = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 64'h500; bus.id_ready = 1'b1;
    repeat (3) cyc();
    neg();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.id_valid, 0);
    chk("rst_pc", bus.id_pc, 0);
    chk("rst_instr", bus.id_instr, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_flushed", perf_flushed, 0);
`endif

    // Reset release: request RESET_PC at once, valid two cycles later.
    cyc(); rst_n = 1'b1; bus.redirect = 1'b0;
    neg();
    chk("c0_req", bus.imem_req, 1);
    chk("c0_addr", bus.imem_addr, RST_PC);
    chk("c0_valid", bus.id_valid, 0);
    cyc(); neg();
    chk("c1_valid", bus.id_valid, 0);
    cyc(); neg();
    chk("c2_valid", bus.id_valid, 1);
    chk("c2_pc", bus.id_pc, 64'h0);
    chk("c2_instr", bus.id_instr, 32'h00730233);
    cyc(); neg();
    chk("c3_pc", bus.id_pc, 64'h4);
    chk("c3_instr", bus.id_instr, 32'h40b504b3);
    repeat (3) cyc();   // pcs 8, C, 10 consumed

    // Decode stall for 5 cycles.
    cyc(); bus.id_ready = 1'b0;
    neg();
    chk("stall_pc_first", bus.id_pc, 64'h14);
    nreq = int'(bus.imem_req);
    repeat (4) begin
      cyc(); neg();
      nreq += int'(bus.imem_req);
    end
    chk("stall_reqs_le2", (nreq <= 2), 1);
    chk("stall_pc_last", bus.id_pc, 64'h14);
    cyc(); bus.id_ready = 1'b1;
    neg();
    chk("stall_resume_pc", bus.id_pc, 64'h14);
    repeat (6) cyc();

    // Redirect table.
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < tbl[i].stall; s++) begin
        cyc(); bus.id_ready = 1'b0;
      end
      cyc(); bus.id_ready = tbl[i].rdy; bus.redirect = 1'b1; bus.redirect_pc = tbl[i].rpc;
      exp_flushed++;
      neg();
      chk("rd_req_blocked", bus.imem_req, 0);
      cyc(); bus.redirect = 1'b0; bus.id_ready = 1'b1;
      neg();
      chk("rd_r1_req", bus.imem_req, 1);
      chk("rd_r1_addr", bus.imem_addr, tbl[i].exp_pc);
      chk("rd_r1_valid", bus.id_valid, 0);
      cyc(); neg();
      chk("rd_r2_valid", bus.id_valid, 0);
      cyc(); neg();
      chk("rd_r3_valid", bus.id_valid, 1);
      chk("rd_r3_pc", bus.id_pc, tbl[i].exp_pc);
      chk("rd_r3_instr", bus.id_instr, mem_word(tbl[i].exp_pc));
      repeat (4) cyc();
    end

    // Redirect coincident with a handshake, then a second redirect.
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 64'h300; bus.id_ready = 1'b1;
    exp_flushed++;
    neg();
    chk("b2b_hs_valid", bus.id_valid, 1);
    cyc(); bus.redirect_pc = 64'h200;
    neg();
    chk("b2b_r1_req", bus.imem_req, 0);
    chk("b2b_r1_valid", bus.id_valid, 0);
    cyc(); bus.redirect = 1'b0;
    neg();
    chk("b2b_req", bus.imem_req, 1);
    chk("b2b_addr", bus.imem_addr, 64'h200);
    chk("b2b_valid_a", bus.id_valid, 0);
    cyc(); neg();
    chk("b2b_valid_b", bus.id_valid, 0);
    cyc(); neg();
    chk("b2b_valid", bus.id_valid, 1);
    chk("b2b_pc", bus.id_pc, 64'h200);
    repeat (4) cyc();

`ifdef FETCH_PERF_CNT_EN
    cyc(); bus.id_ready = 1'b0;
    neg();
    chk("perf_fetched", perf_fetched, 32'(hs_cnt));
    chk("perf_flushed", perf_flushed, 32'(exp_flushed));
    cyc(); bus.id_ready = 1'b1;
`endif

    // Mid-stream reset with a redirect and an in-flight response.
    repeat (2) cyc();
    cyc(); rst_n = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 64'h500;
    neg();
    chk("mrst_req", bus.imem_req, 0);
    cyc(); rst_n = 1'b1; bus.redirect = 1'b0;
    exp_flushed = 0;
    neg();
    chk("mrst_c0_req", bus.imem_req, 1);
    chk("mrst_c0_addr", bus.imem_addr, RST_PC);
    chk("mrst_c0_valid", bus.id_valid, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_perf_fetched", perf_fetched, 0);
    chk("mrst_perf_flushed", perf_flushed, 0);
`endif
    cyc(); neg();
    chk("mrst_c1_valid", bus.id_valid, 0);
    cyc(); neg();
    chk("mrst_c2_valid", bus.id_valid, 1);
    chk("mrst_c2_pc", bus.id_pc, RST_PC);
    chk("mrst_c2_instr", bus.id_instr, 32'h00730233);
    repeat (6) cyc();

`ifdef FETCH_PERF_CNT_EN
    cyc(); bus.id_ready = 1'b0;
    neg();
    chk("perf_fetched_end", perf_fetched, 32'(hs_cnt));
    chk("perf_flushed_end", perf_flushed, 32'(exp_flushed));
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
